// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the core/host data-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one data memory between a running core and a host port,
// with a bounded host wait that stalls the core once the limit is hit.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int HOST_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              CoreDone,
    output logic              CoreRun,
    output logic              CoreStall,
    input  logic              CWen,
    input  logic              CRen,
    input  logic [ADDR_W-1:0] CAddr,
    input  logic [DATA_W-1:0] CWdat,
    output logic [DATA_W-1:0] CRdat,
    input  logic              HReq,
    input  logic              HWe,
    input  logic [ADDR_W-1:0] HAddr,
    input  logic [DATA_W-1:0] HWdat,
    output logic              HGnt,
    output logic [DATA_W-1:0] HRdat,
    output logic              HValid,
    output logic              MWen,
    output logic [ADDR_W-1:0] MAddr,
    output logic [DATA_W-1:0] MWdat,
    input  logic [DATA_W-1:0] MRdat,
    output logic              Finished
);

    localparam int CNT_W = (HOST_MAX < 1) ? 1 : $clog2(HOST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOST_MAX);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_run, core_acc, starve, gnt;

    // Reset gates the decode so grants and writes die the moment it rises.
    always_comb begin
        in_run   = (state == RUN) && !Reset;
        core_acc = CWen | CRen;
        starve   = in_run && HReq && core_acc && (wait_cnt == CNT_MAX);
        if (Reset)
            gnt = 1'b0;
        else if (in_run)
            gnt = HReq && (!core_acc || starve);
        else
            gnt = HReq;
    end

    always_comb begin
        MAddr = CAddr;
        MWdat = CWdat;
        MWen  = 1'b0;
        if (gnt) begin
            MAddr = HAddr;
            MWdat = HWdat;
            MWen  = HWe;
        end else if (in_run) begin
            MWen  = CWen;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HALT:    if (Start)    state_nxt = RUN;
            RUN:     if (CoreDone) state_nxt = FIN;
            FIN:     if (Start)    state_nxt = RUN;
            default: state_nxt = HALT;
        endcase
    end

    assign HGnt      = gnt;
    assign CoreStall = starve;
    assign CRdat     = MRdat;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= HALT;
            wait_cnt <= '0;
            HRdat    <= '0;
            HValid   <= 1'b0;
            CoreRun  <= 1'b0;
            Finished <= 1'b0;
        end else begin
            state    <= state_nxt;
            CoreRun  <= (state_nxt == RUN);
            Finished <= (state_nxt == FIN);
            // Only an ungranted, still-pending host request in a steady RUN ages.
            if (state_nxt != state || !in_run || gnt || !HReq)
                wait_cnt <= '0;
            else if (wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + CNT_W'(1);
            HValid <= gnt && !HWe;
            if (gnt && !HWe)
                HRdat <= MRdat;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a state/wait/memory reference model.
module tb_mem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int HOST_MAX = 4;

    logic              Clk = 1'b0;
    logic              Reset, Start, CoreDone, CoreRun, CoreStall;
    logic              CWen, CRen, HReq, HWe, HGnt, HValid, MWen, Finished;
    logic [ADDR_W-1:0] CAddr, HAddr, MAddr;
    logic [DATA_W-1:0] CWdat, CRdat, HWdat, HRdat, MWdat, MRdat;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_MAX(HOST_MAX)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .CoreDone(CoreDone),
        .CoreRun(CoreRun), .CoreStall(CoreStall), .CWen(CWen), .CRen(CRen),
        .CAddr(CAddr), .CWdat(CWdat), .CRdat(CRdat), .HReq(HReq), .HWe(HWe),
        .HAddr(HAddr), .HWdat(HWdat), .HGnt(HGnt), .HRdat(HRdat), .HValid(HValid),
        .MWen(MWen), .MAddr(MAddr), .MWdat(MWdat), .MRdat(MRdat), .Finished(Finished)
    );

    always #5 Clk = ~Clk;

    // Environment memory attached to the DUT
    logic [DATA_W-1:0] mem [0:255];
    logic              mem_ready = 1'b0;
    assign MRdat = mem[MAddr];
    always @(posedge Clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem_ready <= 1'b1;
        end else if (MWen) begin
            mem[MAddr] <= MWdat;
        end
    end

    // Reference model: 0=HALT 1=RUN 2=FIN, host wait age, memory image
    int                ref_state, ref_wait;
    logic [DATA_W-1:0] ref_mem [0:255];
    logic [DATA_W-1:0] exp_hrdat;
    logic              exp_hvalid;

    function automatic logic model_grant();
        if (ref_state != 1) return HReq;
        return HReq && (!(CWen | CRen) || ref_wait >= HOST_MAX);
    endfunction

    function automatic logic model_stall();
        return (ref_state == 1) && HReq && (CWen | CRen) && (ref_wait >= HOST_MAX);
    endfunction

    function automatic logic model_mwen();
        if (model_grant()) return HWe;
        return (ref_state == 1) && CWen;
    endfunction

    task automatic model_reset();
        ref_state  = 0;
        ref_wait   = 0;
        exp_hrdat  = '0;
        exp_hvalid = 1'b0;
    endtask

    // Apply one clock of the model with the current inputs, then clock the DUT.
    task automatic advance();
        logic g;
        int   ns;
        g = model_grant();
        exp_hvalid = g && !HWe;
        if (g && !HWe) exp_hrdat = ref_mem[HAddr];
        if (g && HWe) ref_mem[HAddr] = HWdat;
        else if (ref_state == 1 && !g && CWen) ref_mem[CAddr] = CWdat;
        ns = ref_state;
        if (ref_state == 0 && Start) ns = 1;
        else if (ref_state == 1 && CoreDone) ns = 2;
        else if (ref_state == 2 && Start) ns = 1;
        if (ref_state == 1 && ns == 1 && HReq && !g)
            ref_wait = (ref_wait + 1 > HOST_MAX) ? HOST_MAX : ref_wait + 1;
        else
            ref_wait = 0;
        ref_state = ns;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Start = 0; CoreDone = 0; CWen = 0; CRen = 0; CAddr = '0; CWdat = '0;
        HReq = 0; HWe = 0; HAddr = '0; HWdat = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1;
        HReq = 1; HWe = 1; HAddr = 8'h11; HWdat = 8'h22;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        n_checks++;
        if ({HGnt, MWen, CoreRun, CoreStall, Finished, HValid} !== 6'b0)
            $display("FAIL reset_outputs got %b want 000000",
                     {HGnt, MWen, CoreRun, CoreStall, Finished, HValid});
        else n_pass++;
        n_checks++;
        if (HRdat !== 8'h00) $display("FAIL reset_hrdat got %h want 00", HRdat);
        else n_pass++;
        idle_inputs();
        Reset = 0;
        model_reset();
        #3;
    endtask

    task automatic test_halt_host();
        HReq = 1; HWe = 1; HAddr = 8'h10; HWdat = 8'h5A;
        #3;
        n_checks++;
        if (HGnt !== 1 || MWen !== 1 || MAddr !== 8'h10 || MWdat !== 8'h5A)
            $display("FAIL halt_write got gnt=%b wen=%b a=%h d=%h want 1 1 10 5a",
                     HGnt, MWen, MAddr, MWdat);
        else n_pass++;
        advance();
        HWe = 0;
        #3;
        n_checks++;
        if (HGnt !== 1 || MWen !== 0 || MAddr !== 8'h10)
            $display("FAIL halt_read got gnt=%b wen=%b a=%h want 1 0 10", HGnt, MWen, MAddr);
        else n_pass++;
        advance();
        HReq = 0;
        n_checks++;
        if (HValid !== 1 || HRdat !== 8'h5A)
            $display("FAIL halt_rdata got v=%b d=%h want 1 5a", HValid, HRdat);
        else n_pass++;
        advance();
        n_checks++;
        if (HValid !== 0 || HRdat !== 8'h5A)
            $display("FAIL halt_hold got v=%b d=%h want 0 5a", HValid, HRdat);
        else n_pass++;
    endtask

    task automatic test_core_store();
        Start = 1;
        #3;
        n_checks++;
        if (CoreRun !== 0) $display("FAIL start_prerun got %b want 0", CoreRun);
        else n_pass++;
        advance();
        Start = 0;
        CWen = 1; CAddr = 8'h20; CWdat = 8'h33;
        HReq = 1; HWe = 0; HAddr = 8'h10;
        #3;
        n_checks++;
        if (CoreRun !== 1 || HGnt !== 0 || MWen !== 1 || MAddr !== 8'h20 || MWdat !== 8'h33)
            $display("FAIL core_store got run=%b gnt=%b wen=%b a=%h d=%h want 1 0 1 20 33",
                     CoreRun, HGnt, MWen, MAddr, MWdat);
        else n_pass++;
        advance();
        CWen = 0;
        #3;
        n_checks++;
        if (HGnt !== 1 || MAddr !== 8'h10 || MWen !== 0)
            $display("FAIL core_idle_grant got gnt=%b a=%h wen=%b want 1 10 0", HGnt, MAddr, MWen);
        else n_pass++;
        advance();
        HReq = 0;
        n_checks++;
        if (HValid !== 1 || HRdat !== 8'h5A || mem[8'h20] !== 8'h33)
            $display("FAIL core_store_result got v=%b d=%h m20=%h want 1 5a 33",
                     HValid, HRdat, mem[8'h20]);
        else n_pass++;
        advance();
    endtask

    task automatic test_starvation();
        logic exp_g;
        HReq = 1; HWe = 0; HAddr = 8'h20;
        for (int i = 0; i < 10; i++) begin
            // core store to the host's address on the starve cycles must be dropped
            CWen  = (i % 5 == 4);
            CRen  = !(i % 5 == 4);
            CAddr = (i % 5 == 4) ? 8'h20 : 8'h60 + 8'(i);
            CWdat = 8'hEE;
            #3;
            exp_g = (i % 5 == 4);
            n_checks++;
            if (HGnt !== exp_g || CoreStall !== exp_g || HGnt !== model_grant())
                $display("FAIL starve_cycle%0d got gnt=%b stall=%b want %b %b",
                         i, HGnt, CoreStall, exp_g, exp_g);
            else n_pass++;
            n_checks++;
            if (MWen !== model_mwen())
                $display("FAIL starve_wen%0d got %b want %b", i, MWen, model_mwen());
            else n_pass++;
            advance();
            if (exp_g) begin
                n_checks++;
                if (HValid !== 1 || HRdat !== 8'h33)
                    $display("FAIL starve_rdata%0d got v=%b d=%h want 1 33", i, HValid, HRdat);
                else n_pass++;
            end
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_random();
        int acc;
        for (int i = 0; i < 300; i++) begin
            HReq  = ($urandom_range(0, 3) != 0);
            HWe   = 1'($urandom_range(0, 1));
            HAddr = 8'($urandom);
            HWdat = 8'($urandom);
            acc   = $urandom_range(0, 3);
            CWen  = (acc == 1);
            CRen  = (acc >= 2);
            CAddr = 8'($urandom);
            CWdat = 8'($urandom);
            Start = ($urandom_range(0, 15) == 0);
            #3;
            n_checks++;
            if (HGnt !== model_grant() || CoreStall !== model_stall() || MWen !== model_mwen()
                || CoreRun !== 1)
                $display("FAIL rand_ctrl%0d got gnt=%b stall=%b wen=%b run=%b want %b %b %b 1",
                         i, HGnt, CoreStall, MWen, CoreRun, model_grant(), model_stall(), model_mwen());
            else n_pass++;
            if (model_mwen()) begin
                n_checks++;
                if (MAddr !== (model_grant() ? HAddr : CAddr) || MWdat !== (model_grant() ? HWdat : CWdat))
                    $display("FAIL rand_wr%0d got a=%h d=%h", i, MAddr, MWdat);
                else n_pass++;
            end
            advance();
            n_checks++;
            if (HValid !== exp_hvalid || HRdat !== exp_hrdat)
                $display("FAIL rand_rd%0d got v=%b d=%h want %b %h", i, HValid, HRdat, exp_hvalid, exp_hrdat);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_done_fin();
        CoreDone = 1; CRen = 1; CAddr = 8'h01;
        HReq = 1; HWe = 0; HAddr = 8'h10;
        #3;
        n_checks++;
        if (CoreRun !== 1 || HGnt !== model_grant() || CoreStall !== model_stall())
            $display("FAIL done_cycle got run=%b gnt=%b stall=%b want 1 %b %b",
                     CoreRun, HGnt, CoreStall, model_grant(), model_stall());
        else n_pass++;
        advance();
        CoreDone = 0;
        for (int i = 0; i < 3; i++) begin
            HAddr = 8'($urandom);
            #3;
            n_checks++;
            if (Finished !== 1 || CoreRun !== 0 || HGnt !== 1 || CoreStall !== 0)
                $display("FAIL fin_cycle%0d got fin=%b run=%b gnt=%b stall=%b want 1 0 1 0",
                         i, Finished, CoreRun, HGnt, CoreStall);
            else n_pass++;
            advance();
            n_checks++;
            if (HValid !== 1 || HRdat !== exp_hrdat)
                $display("FAIL fin_rdata%0d got v=%b d=%h want 1 %h", i, HValid, HRdat, exp_hrdat);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] keep;
        keep = ref_mem[8'h40];
        HReq = 1; HWe = 1; HAddr = 8'h40; HWdat = ~keep;
        #2;
        n_checks++;
        if (Finished !== 1 || HGnt !== 1 || MWen !== 1)
            $display("FAIL mid_pre got fin=%b gnt=%b wen=%b want 1 1 1", Finished, HGnt, MWen);
        else n_pass++;
        Reset = 1;
        #1;
        n_checks++;
        if ({MWen, HGnt, Finished, CoreRun, CoreStall, HValid} !== 6'b0 || HRdat !== 8'h00)
            $display("FAIL mid_reset got %b hrdat=%h want 000000 00",
                     {MWen, HGnt, Finished, CoreRun, CoreStall, HValid}, HRdat);
        else n_pass++;
        @(posedge Clk); #1;
        n_checks++;
        if (mem[8'h40] !== keep) $display("FAIL mid_nowrite got %h want %h", mem[8'h40], keep);
        else n_pass++;
        idle_inputs();
        Reset = 0;
        model_reset();
        Start = 1;
        advance();
        n_checks++;
        if (CoreRun !== 1 || Finished !== 0)
            $display("FAIL restart got run=%b fin=%b want 1 0", CoreRun, Finished);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            advance();
            n_checks++;
            if (CoreRun !== 1 || Finished !== 0)
                $display("FAIL start_in_run%0d got run=%b fin=%b want 1 0", i, CoreRun, Finished);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_halt_host();
        test_core_store();
        test_starvation();
        test_random();
        test_done_fin();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
